// File: rtl/imm_encoder_pkg.sv
// Shared immediate-format codes, opcodes and FSM encoding for the immediate encoder.
package imm_encoder_pkg;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    typedef enum logic [1:0] {
        EMPTY      = 2'd0,
        HOLD_FIRST = 2'd1,
        HOLD_LAST  = 2'd2
    } enc_state_t;

    // True when the value survives a round trip through a 12-bit signed field.
    function automatic logic fits12(input logic [31:0] imm);
        return (&imm[31:11]) | ~(|imm[31:11]);
    endfunction

endpackage

// File: rtl/imm_encoder_pack.sv
// Scatters an immediate into the format's bit positions of a base instruction and flags range errors.
// Purely combinational; no handshake.
module imm_pack
    import imm_encoder_pkg::*;
(
    input  logic [2:0]  sel,
    input  logic [31:0] base,
    input  logic [31:0] imm,
    output logic [31:0] inst,
    output logic        err
);

    logic signed [31:0] simm;
    assign simm = imm;

    always_comb begin
        inst = base;
        err  = 1'b0;
        case (sel)
            IMM_I: begin
                inst = {imm[11:0], base[19:0]};
                err  = (simm < -32'sd2048) || (simm > 32'sd2047);
            end
            IMM_S: begin
                inst = {imm[11:5], base[24:12], imm[4:0], base[6:0]};
                err  = (simm < -32'sd2048) || (simm > 32'sd2047);
            end
            IMM_B: begin
                inst = {imm[12], imm[10:5], base[24:12], imm[4:1], imm[11], base[6:0]};
                err  = imm[0] || (simm < -32'sd4096) || (simm > 32'sd4094);
            end
            IMM_U: begin
                inst = {imm[31:12], base[11:0]};
                err  = |imm[11:0];
            end
            IMM_J: begin
                inst = {imm[20], imm[10:1], imm[11], imm[19:12], base[11:0]};
                err  = imm[0] || (simm < -32'sd1048576) || (simm > 32'sd1048574);
            end
            default: begin
                // Unknown format: pass the base through untouched but flag it.
                inst = base;
                err  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_encoder.sv
// Immediate encoder with load-immediate expansion; one registered output word per cycle.
// Input stalls while a word is held unless it is the last word and is consumed this cycle.
module imm_encoder
    import imm_encoder_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_sel,
    input  logic        in_li,
    input  logic [31:0] in_base,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic        out_last,
    output logic        out_err
);

    enc_state_t  state, state_nxt;
    logic [31:0] side_inst;
    logic        accept;

    logic [4:0]  rd;
    logic        li_fits;
    logic        li_two;
    logic [19:0] li_hi;
    logic [11:0] li_lo;
    logic [31:0] addi_word;

    logic [2:0]  pack_sel;
    logic [31:0] pack_base;
    logic [31:0] pack_imm;
    logic [31:0] pack_inst;
    logic        pack_err;

    assign rd      = in_base[11:7];
    assign li_fits = fits12(in_imm);
    assign li_lo   = in_imm[11:0];
    // Rounding the upper part up compensates for the sign-extended ADDI that follows.
    assign li_hi   = in_imm[31:12] + {19'd0, in_imm[11]};
    assign li_two  = in_li & ~li_fits & (li_lo != 12'd0);
    assign addi_word = {li_lo, rd, 3'b000, rd, OP_IMM};

    always_comb begin
        pack_sel  = in_sel;
        pack_base = in_base;
        pack_imm  = in_imm;
        if (in_li) begin
            if (li_fits) begin
                pack_sel  = IMM_I;
                pack_base = {12'd0, 5'd0, 3'b000, rd, OP_IMM};
                pack_imm  = in_imm;
            end else begin
                pack_sel  = IMM_U;
                pack_base = {20'd0, rd, OP_LUI};
                pack_imm  = {li_hi, 12'd0};
            end
        end
    end

    imm_pack u_pack (
        .sel  (pack_sel),
        .base (pack_base),
        .imm  (pack_imm),
        .inst (pack_inst),
        .err  (pack_err)
    );

    assign accept = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= EMPTY;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:      if (accept) state_nxt = li_two ? HOLD_FIRST : HOLD_LAST;
            HOLD_FIRST: if (out_ready) state_nxt = HOLD_LAST;
            HOLD_LAST: begin
                if (accept)         state_nxt = li_two ? HOLD_FIRST : HOLD_LAST;
                else if (out_ready) state_nxt = EMPTY;
            end
            default:    state_nxt = EMPTY;
        endcase
    end

    always_comb begin
        in_ready  = (state == EMPTY) | ((state == HOLD_LAST) & out_ready);
        out_valid = (state != EMPTY);
        out_last  = (state == HOLD_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_inst  <= 32'd0;
            out_err   <= 1'b0;
            side_inst <= 32'd0;
        end else if (accept) begin
            out_inst  <= pack_inst;
            out_err   <= pack_err & ~in_li;
            side_inst <= addi_word;
        end else if ((state == HOLD_FIRST) && out_ready) begin
            out_inst  <= side_inst;
            out_err   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_imm_encoder.sv
// Bench for imm_encoder: directed vector table, handshake corner sequences, randomized round trips.
module tb_imm_encoder;
    import imm_encoder_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_sel = 3'd0;
    logic        in_li = 1'b0;
    logic [31:0] in_base = 32'd0;
    logic [31:0] in_imm = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_inst;
    logic        out_last;
    logic        out_err;

    int nchk = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    imm_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_li     (in_li),
        .in_base   (in_base),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inst  (out_inst),
        .out_last  (out_last),
        .out_err   (out_err)
    );

    typedef struct {
        logic        li;
        logic [2:0]  sel;
        logic [31:0] base;
        logic [31:0] imm;
        int          nw;
        logic [31:0] w0;
        logic [31:0] w1;
        logic        err;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference decoder, as the core sees immediates.
    function automatic logic [31:0] decode(input logic [2:0] s, input logic [31:0] i);
        case (s)
            IMM_I:   return {{20{i[31]}}, i[31:20]};
            IMM_S:   return {{20{i[31]}}, i[31:25], i[11:7]};
            IMM_B:   return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            IMM_U:   return {i[31:12], 12'd0};
            default: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
        endcase
    endfunction

    function automatic logic [31:0] keep_mask(input logic [2:0] s);
        case (s)
            IMM_I:        return 32'h000F_FFFF;
            IMM_S, IMM_B: return 32'h01FF_F07F;
            default:      return 32'h0000_0FFF;
        endcase
    endfunction

    function automatic logic ref_err(input logic [2:0] s, input logic [31:0] imm);
        longint v;
        v = longint'($signed(imm));
        case (s)
            IMM_I, IMM_S: return (v < -2048) || (v > 2047);
            IMM_B:        return imm[0] || (v < -4096) || (v > 4094);
            IMM_U:        return imm[11:0] != 12'd0;
            IMM_J:        return imm[0] || (v < -(64'sd1 <<< 20)) || (v > (64'sd1 <<< 20) - 2);
            default:      return 1'b1;
        endcase
    endfunction

    // Issue one request with out_ready held high and collect up to two words.
    task automatic do_req(input logic li, input logic [2:0] sel, input logic [31:0] base,
                          input logic [31:0] imm, output int nw,
                          output logic [31:0] w0, output logic [31:0] w1,
                          output logic e0, output logic e1,
                          output logic l0, output logic l1,
                          output logic rdy_hold, output logic lat_ok);
        int b;
        nw = 0; w0 = '0; w1 = '0; e0 = 0; e1 = 0; l0 = 0; l1 = 0; rdy_hold = 1; lat_ok = 0;
        out_ready = 1'b1;
        in_li = li; in_sel = sel; in_base = base; in_imm = imm; in_valid = 1'b1;
        b = 0;
        while (!in_ready && b < 20) begin
            @(posedge clk); #1; b++;
        end
        if (!in_ready) begin
            nchk++; nfail++;
            $display("FAIL accept_timeout: in_ready stayed 0, expected 1");
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat_ok = out_valid;
        for (int k = 0; k < 3; k++) begin
            if (out_valid) begin
                if (nw == 0) begin
                    w0 = out_inst; e0 = out_err; l0 = out_last;
                    if (!out_last) rdy_hold = in_ready;
                end else begin
                    w1 = out_inst; e1 = out_err; l1 = out_last;
                end
                nw++;
                if (out_last || nw == 2) break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    vec_t vecs[15];

    initial begin
        int nw;
        logic [31:0] w0, w1;
        logic e0, e1, l0, l1, rh, lat;

        vecs[0]  = '{1'b0, IMM_I, 32'h0000_0093, 32'hFFFF_FFFF, 1, 32'hFFF0_0093, 32'h0, 1'b0};
        vecs[1]  = '{1'b0, IMM_B, 32'h0000_0063, 32'h0000_0800, 1, 32'h0000_00E3, 32'h0, 1'b0};
        vecs[2]  = '{1'b0, IMM_B, 32'h0000_0063, 32'd4096,      1, 32'h8000_0063, 32'h0, 1'b1};
        vecs[3]  = '{1'b0, IMM_B, 32'h0000_0063, 32'd3,         1, 32'h0000_0163, 32'h0, 1'b1};
        vecs[4]  = '{1'b1, IMM_J, 32'h0000_0280, 32'h1234_5FFF, 2, 32'h1234_62B7, 32'hFFF2_8293, 1'b0};
        vecs[5]  = '{1'b1, IMM_I, 32'h0000_0080, 32'd5,         1, 32'h0050_0093, 32'h0, 1'b0};
        vecs[6]  = '{1'b1, IMM_I, 32'h0000_0080, 32'h0000_1000, 1, 32'h0000_10B7, 32'h0, 1'b0};
        vecs[7]  = '{1'b0, 3'd7,  32'hDEAD_BEEF, 32'h0,         1, 32'hDEAD_BEEF, 32'h0, 1'b1};
        vecs[8]  = '{1'b0, IMM_S, 32'h0000_2023, 32'hFFFF_FFFC, 1, 32'hFE00_2E23, 32'h0, 1'b0};
        vecs[9]  = '{1'b0, IMM_U, 32'h0000_0037, 32'h1234_5000, 1, 32'h1234_5037, 32'h0, 1'b0};
        vecs[10] = '{1'b0, IMM_J, 32'h0000_006F, 32'h0000_0800, 1, 32'h0010_006F, 32'h0, 1'b0};
        vecs[11] = '{1'b0, IMM_J, 32'h0000_006F, 32'h0010_0000, 1, 32'h8000_006F, 32'h0, 1'b1};
        vecs[12] = '{1'b1, IMM_I, 32'h0000_0F80, 32'hFFFF_F800, 1, 32'h8000_0F93, 32'h0, 1'b0};
        vecs[13] = '{1'b1, IMM_I, 32'h0000_0100, 32'h7FFF_F800, 2, 32'h8000_0137, 32'h8001_0113, 1'b0};
        vecs[14] = '{1'b0, IMM_I, 32'h0000_0093, 32'h0000_0800, 1, 32'h8000_0093, 32'h0, 1'b1};

        // Reset state
        #2;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_inst", out_inst, 32'd0);
        chk("rst_out_last", {31'd0, out_last}, 32'd0);
        chk("rst_out_err", {31'd0, out_err}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors
        for (int i = 0; i < 15; i++) begin
            do_req(vecs[i].li, vecs[i].sel, vecs[i].base, vecs[i].imm, nw, w0, w1, e0, e1, l0, l1, rh, lat);
            chk($sformatf("v%0d_latency", i), {31'd0, lat}, 32'd1);
            chk($sformatf("v%0d_nwords", i), nw, vecs[i].nw);
            chk($sformatf("v%0d_word0", i), w0, vecs[i].w0);
            chk($sformatf("v%0d_err0", i), {31'd0, e0}, {31'd0, vecs[i].err});
            chk($sformatf("v%0d_last0", i), {31'd0, l0}, {31'd0, vecs[i].nw == 1});
            if (vecs[i].nw == 2) begin
                chk($sformatf("v%0d_word1", i), w1, vecs[i].w1);
                chk($sformatf("v%0d_last1", i), {31'd0, l1}, 32'd1);
                chk($sformatf("v%0d_err1", i), {31'd0, e1}, 32'd0);
                chk($sformatf("v%0d_ready_in_first", i), {31'd0, rh}, 32'd0);
            end
        end

        // Back-pressure: word stable, no new accept, then fire+accept in one edge
        out_ready = 1'b0;
        in_li = 1'b0; in_sel = IMM_I; in_base = 32'h0000_0013; in_imm = 32'd1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_imm = 32'd2;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("bp_stable_%0d", k), out_inst, 32'h0010_0013);
            chk($sformatf("bp_valid_%0d", k), {31'd0, out_valid}, 32'd1);
            chk($sformatf("bp_no_accept_%0d", k), {31'd0, in_ready}, 32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        chk("bp_ready_follows_out_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("b2b_next_word", out_inst, 32'h0020_0013);
        chk("b2b_valid", {31'd0, out_valid}, 32'd1);
        @(posedge clk); #1;
        chk("b2b_drained", {31'd0, out_valid}, 32'd0);

        // Reset during HOLD_FIRST drops the pending ADDI
        out_ready = 1'b0;
        in_li = 1'b1; in_base = 32'h0000_0280; in_imm = 32'h1234_5FFF; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("mid_li_first_held", {31'd0, out_last}, 32'd0);
        rst_n = 1'b0;
        #2;
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_inst", out_inst, 32'd0);
        chk("mid_rst_last", {31'd0, out_last}, 32'd0);
        chk("mid_rst_err", {31'd0, out_err}, 32'd0);
        chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            chk($sformatf("post_rst_idle_%0d", k), {31'd0, out_valid}, 32'd0);
        end

        // Random format round trip against the decoder
        for (int i = 0; i < 200; i++) begin
            logic [2:0]  s;
            logic [31:0] r, imm, base;
            s = 3'($urandom_range(0, 4));
            r = $urandom;
            base = $urandom;
            case ($urandom_range(0, 4))
                0: imm = r;
                1: imm = {{20{r[11]}}, r[11:0]};
                2: imm = {{19{r[12]}}, r[12:1], 1'b0};
                3: imm = {{11{r[20]}}, r[20:1], 1'b0};
                default: imm = {r[31:12], 12'd0};
            endcase
            do_req(1'b0, s, base, imm, nw, w0, w1, e0, e1, l0, l1, rh, lat);
            chk($sformatf("rnd%0d_nwords", i), nw, 1);
            chk($sformatf("rnd%0d_err", i), {31'd0, e0}, {31'd0, ref_err(s, imm)});
            chk($sformatf("rnd%0d_fields", i), w0 & keep_mask(s), base & keep_mask(s));
            if (!ref_err(s, imm))
                chk($sformatf("rnd%0d_decode", i), decode(s, w0), imm);
        end

        // Random LI: execute the emitted words and compare the register value
        for (int i = 0; i < 200; i++) begin
            logic [31:0] r, imm, base, x, w;
            logic [4:0]  rd;
            longint      v;
            int          exp_nw;
            r = $urandom;
            case ($urandom_range(0, 3))
                0: imm = r;
                1: imm = {{20{r[11]}}, r[11:0]};
                2: imm = {r[31:12], 12'd0};
                default: imm = {r[31:12], 1'b1, 11'h7FF};
            endcase
            rd = 5'($urandom_range(1, 31));
            base = $urandom;
            base[11:7] = rd;
            v = longint'($signed(imm));
            exp_nw = ((v >= -2048 && v <= 2047) || imm[11:0] == 12'd0) ? 1 : 2;
            do_req(1'b1, 3'($urandom_range(0, 7)), base, imm, nw, w0, w1, e0, e1, l0, l1, rh, lat);
            chk($sformatf("li%0d_nwords", i), nw, exp_nw);
            chk($sformatf("li%0d_err", i), {31'd0, e0 | e1}, 32'd0);
            x = 32'd0;
            for (int k = 0; k < nw && k < 2; k++) begin
                w = (k == 0) ? w0 : w1;
                chk($sformatf("li%0d_rd%0d", i, k), {27'd0, w[11:7]}, {27'd0, rd});
                if (w[6:0] == OP_LUI)
                    x = {w[31:12], 12'd0};
                else
                    x = ((w[19:15] == 5'd0) ? 32'd0 : x) + {{20{w[31]}}, w[31:20]};
            end
            chk($sformatf("li%0d_value", i), x, imm);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
